// File: rtl/mem_access_unit.sv
// Memory-access stage: turns one ALU memory command into a single handshaked
// bus transaction with wait states and timeout, then reports completion to the ALU.
module mem_access_unit #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        MemIO,
    input  logic [ADDR_W-1:0] ALUAddr,
    inout  wire  [DATA_W-1:0] DataIO,
    output logic              ValidMemData,
    output logic              MemErr,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    // Last counter value that still counts as a BUS cycle; mem_req stays up TIMEOUT cycles.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t            state_q;
    logic [7:0]        cnt_q;
    logic              req_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              valid_q;
    logic              err_q;
    logic              drive_q;

    // Transaction FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            drive_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    valid_q <= 1'b0;
                    drive_q <= 1'b0;
                    if (MemIO == 2'b01 || MemIO == 2'b10) begin
                        addr_q  <= ALUAddr;
                        we_q    <= MemIO[1];
                        cnt_q   <= 8'd0;
                        req_q   <= 1'b1;
                        err_q   <= 1'b0;
                        state_q <= ST_BUS;
                        if (MemIO[1]) begin
                            wdata_q <= DataIO;
                        end else begin
                            wdata_q <= wdata_q;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_BUS: begin
                    if (mem_ack) begin
                        rdata_q <= mem_rdata;
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                        err_q   <= 1'b0;
                        drive_q <= ~we_q;
                        state_q <= ST_DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        rdata_q <= '0;
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                        err_q   <= 1'b1;
                        drive_q <= ~we_q;
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q   <= cnt_q + 8'd1;
                    end
                end
                ST_DONE: begin
                    valid_q <= 1'b0;
                    drive_q <= 1'b0;
                    state_q <= ST_HOLD;
                end
                ST_HOLD: begin
                    // The ALU must release its command before another one is accepted.
                    if (MemIO == 2'b00) begin
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_HOLD;
                    end
                end
                default: begin
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                    drive_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign DataIO       = drive_q ? rdata_q : {DATA_W{1'bz}};
    assign ValidMemData = valid_q;
    assign MemErr       = err_q;
    assign mem_req      = req_q;
    assign mem_we       = we_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed plus randomized bench for mem_access_unit; expected bus behaviour is
// derived from wait count / timeout rules per transaction.
module tb_mem_access_unit;

    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  MemIO;
    logic [31:0] ALUAddr;
    wire  [31:0] DataIO;
    logic        ValidMemData;
    logic        MemErr;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    logic        tb_drv_en;
    logic [31:0] tb_dval;
    int          total = 0;
    int          bad   = 0;

    assign DataIO = tb_drv_en ? tb_dval : 32'hzzzz_zzzz;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .MemIO(MemIO), .ALUAddr(ALUAddr), .DataIO(DataIO),
        .ValidMemData(ValidMemData), .MemErr(MemErr), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One transaction: waits<0 means the memory never acks; hold = cycles the
    // command stays asserted after completion.
    task automatic run_txn(input logic [1:0] cmd, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] rd,
                           input int waits, input int hold);
        int          reqc;
        int          exp_req;
        logic        exp_err;
        logic [31:0] exp_rd;
        exp_err = (waits < 0 || waits >= TIMEOUT);
        exp_req = exp_err ? TIMEOUT : waits + 1;
        exp_rd  = exp_err ? 32'h0 : rd;
        MemIO = cmd; ALUAddr = addr; tb_drv_en = cmd[1]; tb_dval = wd; mem_ack = 1'b0;
        reqc = 0;
        @(negedge clk);
        while (mem_req === 1'b1 && reqc < TIMEOUT + 2) begin
            reqc++;
            chk("bus_we", 32'(mem_we), 32'(cmd[1]));
            chk("bus_addr", mem_addr, addr);
            if (cmd[1]) chk("bus_wdata", mem_wdata, wd);
            chk("bus_valid", 32'(ValidMemData), 32'h0);
            chk("bus_err", 32'(MemErr), 32'h0);
            ALUAddr   = $urandom;
            tb_dval   = $urandom;
            MemIO     = 2'($urandom_range(0, 3));
            mem_ack   = (waits >= 0 && reqc == waits + 1);
            mem_rdata = mem_ack ? rd : $urandom;
            @(negedge clk);
        end
        mem_ack = 1'($urandom_range(0, 1));
        chk("req_cycles", 32'(reqc), 32'(exp_req));
        chk("done_valid", 32'(ValidMemData), 32'h1);
        chk("done_err", 32'(MemErr), 32'(exp_err));
        chk("done_req", 32'(mem_req), 32'h0);
        if (!cmd[1]) chk("done_rdata", DataIO, exp_rd);
        else         chk("done_bus_free", DataIO, tb_dval);
        MemIO = (hold > 0) ? cmd : 2'b00;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_req", 32'(mem_req), 32'h0);
            chk("hold_valid", 32'(ValidMemData), 32'h0);
            chk("hold_err", 32'(MemErr), 32'(exp_err));
            MemIO   = ($urandom_range(0, 3) == 0) ? 2'b11 : cmd;
            mem_ack = 1'($urandom_range(0, 1));
        end
        MemIO = 2'b00;
        repeat (2) begin
            @(negedge clk);
            chk("idle_req", 32'(mem_req), 32'h0);
            chk("idle_valid", 32'(ValidMemData), 32'h0);
        end
        mem_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; MemIO = 2'b00; ALUAddr = 32'h0; mem_rdata = 32'h0; mem_ack = 1'b0;
        tb_drv_en = 1'b0; tb_dval = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_req", 32'(mem_req), 32'h0);
        chk("rst_we", 32'(mem_we), 32'h0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_valid", 32'(ValidMemData), 32'h0);
        chk("rst_err", 32'(MemErr), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases.
        run_txn(2'b01, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0, 0);
        run_txn(2'b10, 32'h0000_0020, 32'h1234_5678, 32'h0, 3, 0);
        run_txn(2'b01, 32'h0000_0300, 32'h0, 32'hCAFE_F00D, -1, 1);
        run_txn(2'b01, 32'h0000_0304, 32'h0, 32'h0BAD_CAFE, 0, 0);
        run_txn(2'b01, 32'h0000_0400, 32'h0, 32'h1111_2222, 0, 20);
        run_txn(2'b10, 32'h0000_0404, 32'hA5A5_5A5A, 32'h0, 0, 0);
        run_txn(2'b01, 32'h0000_0500, 32'h0, 32'h3333_4444, TIMEOUT - 1, 0);
        run_txn(2'b10, 32'h0000_0504, 32'h5555_6666, 32'h0, -1, 0);

        // Reset while waiting in BUS; the late ack must be discarded.
        MemIO = 2'b01; ALUAddr = 32'h0000_0040; tb_drv_en = 1'b0; mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("rstbus_req_before", 32'(mem_req), 32'h1);
        rst = 1'b1; MemIO = 2'b00;
        @(negedge clk);
        chk("rstbus_req", 32'(mem_req), 32'h0);
        chk("rstbus_addr", mem_addr, 32'h0);
        chk("rstbus_we", 32'(mem_we), 32'h0);
        chk("rstbus_valid", 32'(ValidMemData), 32'h0);
        chk("rstbus_err", 32'(MemErr), 32'h0);
        rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hFFFF_0000;
        @(negedge clk);
        chk("rstbus_ack_req", 32'(mem_req), 32'h0);
        chk("rstbus_ack_valid", 32'(ValidMemData), 32'h0);
        mem_ack = 1'b0;
        @(negedge clk);
        chk("rstbus_late_valid", 32'(ValidMemData), 32'h0);

        // Reserved command and stray acks while idle.
        MemIO = 2'b11;
        for (int i = 0; i < 4; i++) begin
            mem_ack = i[0];
            @(negedge clk);
            chk("spur_req", 32'(mem_req), 32'h0);
            chk("spur_valid", 32'(ValidMemData), 32'h0);
        end
        MemIO = 2'b00; mem_ack = 1'b0;
        @(negedge clk);
        run_txn(2'b10, 32'h0000_0600, 32'h7777_8888, 32'h0, 1, 0);

        // Randomized transactions.
        for (int t = 0; t < 16; t++) begin
            logic [1:0] cmd;
            int         w;
            cmd = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01;
            w   = ($urandom_range(0, 5) == 0) ? -1 : $urandom_range(0, TIMEOUT + 1);
            run_txn(cmd, $urandom, $urandom, $urandom, w, $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
